// File: rtl/model_read_heads.sv
// Reader end of the DNC interface vector: pulls read keys, read strengths, free gates and read
// modes out of the shared stream and discards write fields. Gate clamp option: NTM_READ_HEADS_GATE_CLAMP_EN.
module model_read_heads #(
    parameter int                    DATA_SIZE    = 64,
    parameter int                    CONTROL_SIZE = 64,
    parameter logic [DATA_SIZE-1:0]  ONE          = 64'h0000_0001_0000_0000
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic [DATA_SIZE-1:0] SIZE_R_IN,
    input  logic [DATA_SIZE-1:0] SIZE_W_IN,
    input  logic                 XI_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] XI_IN,
    output logic [DATA_SIZE-1:0] INDEX_I_OUT,
    output logic [DATA_SIZE-1:0] INDEX_K_OUT,
    output logic                 K_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] K_OUT,
    output logic                 BETA_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] BETA_OUT,
    output logic                 F_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] F_OUT,
    output logic                 PI_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] PI_OUT
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_KEYS      = 3'd1;
    localparam logic [2:0] S_STRENGTHS = 3'd2;
    localparam logic [2:0] S_SKIP_W    = 3'd3;
    localparam logic [2:0] S_FREES     = 3'd4;
    localparam logic [2:0] S_SKIP_G    = 3'd5;
    localparam logic [2:0] S_MODES     = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    localparam logic [CONTROL_SIZE-1:0] C_ONE = CONTROL_SIZE'(1);
    localparam logic [CONTROL_SIZE-1:0] C_TWO = CONTROL_SIZE'(2);

`ifdef NTM_READ_HEADS_GATE_CLAMP_EN
    localparam bit GATE_CLAMP = 1'b1;
`else
    localparam bit GATE_CLAMP = 1'b0;
`endif

    logic [2:0]              state_q, state_d;
    logic [CONTROL_SIZE-1:0] r_q, r_d, w_q, w_d, i_q, i_d, k_q, k_d;
    logic [CONTROL_SIZE-1:0] r_in, w_in;
    logic                    ready_q, ready_d;
    logic [DATA_SIZE-1:0]    idx_i_q, idx_i_d, idx_k_q, idx_k_d;
    logic [DATA_SIZE-1:0]    k_dat_q, k_dat_d, beta_dat_q, beta_dat_d;
    logic [DATA_SIZE-1:0]    f_dat_q, f_dat_d, pi_dat_q, pi_dat_d;
    logic                    k_vld_q, k_vld_d, beta_vld_q, beta_vld_d;
    logic                    f_vld_q, f_vld_d, pi_vld_q, pi_vld_d;
    logic                    i_last, k_last_w;

    // Gates are probabilities: negative values floor at 0, anything above 1.0 saturates.
    function automatic logic [DATA_SIZE-1:0] gate_sat(input logic [DATA_SIZE-1:0] x);
        if (!GATE_CLAMP) return x;
        if (x[DATA_SIZE-1]) return '0;
        if (x > ONE) return ONE;
        return x;
    endfunction

    assign r_in     = CONTROL_SIZE'(SIZE_R_IN);
    assign w_in     = CONTROL_SIZE'(SIZE_W_IN);
    assign i_last   = (i_q + C_ONE) == r_q;
    assign k_last_w = (k_q + C_ONE) == w_q;

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        w_d        = w_q;
        i_d        = i_q;
        k_d        = k_q;
        ready_d    = 1'b0;
        idx_i_d    = idx_i_q;
        idx_k_d    = idx_k_q;
        k_dat_d    = k_dat_q;
        beta_dat_d = beta_dat_q;
        f_dat_d    = f_dat_q;
        pi_dat_d   = pi_dat_q;
        k_vld_d    = 1'b0;
        beta_vld_d = 1'b0;
        f_vld_d    = 1'b0;
        pi_vld_d   = 1'b0;
        case (state_q)
            S_IDLE: if (START) begin
                r_d     = r_in;
                w_d     = w_in;
                i_d     = '0;
                k_d     = '0;
                state_d = (r_in == '0 || w_in == '0) ? S_DONE : S_KEYS;
            end
            S_KEYS: if (XI_IN_ENABLE) begin
                k_dat_d = XI_IN;
                k_vld_d = 1'b1;
                idx_i_d = DATA_SIZE'(i_q);
                idx_k_d = DATA_SIZE'(k_q);
                if (k_last_w) begin
                    k_d = '0;
                    if (i_last) begin
                        i_d     = '0;
                        state_d = S_STRENGTHS;
                    end else begin
                        i_d = i_q + C_ONE;
                    end
                end else begin
                    k_d = k_q + C_ONE;
                end
            end
            S_STRENGTHS: if (XI_IN_ENABLE) begin
                beta_dat_d = XI_IN;
                beta_vld_d = 1'b1;
                idx_i_d    = DATA_SIZE'(i_q);
                idx_k_d    = '0;
                i_d        = i_last ? '0 : i_q + C_ONE;
                if (i_last) state_d = S_SKIP_W;
            end
            // k counts discarded words here: k_w, beta_w, e, v is 3W+1 words.
            S_SKIP_W: if (XI_IN_ENABLE) begin
                if (k_q == w_q + w_q + w_q) begin
                    k_d     = '0;
                    state_d = S_FREES;
                end else begin
                    k_d = k_q + C_ONE;
                end
            end
            S_FREES: if (XI_IN_ENABLE) begin
                f_dat_d = gate_sat(XI_IN);
                f_vld_d = 1'b1;
                idx_i_d = DATA_SIZE'(i_q);
                idx_k_d = '0;
                i_d     = i_last ? '0 : i_q + C_ONE;
                if (i_last) state_d = S_SKIP_G;
            end
            S_SKIP_G: if (XI_IN_ENABLE) begin
                if (k_q == C_ONE) begin
                    k_d     = '0;
                    state_d = S_MODES;
                end else begin
                    k_d = k_q + C_ONE;
                end
            end
            S_MODES: if (XI_IN_ENABLE) begin
                pi_dat_d = gate_sat(XI_IN);
                pi_vld_d = 1'b1;
                idx_i_d  = DATA_SIZE'(i_q);
                idx_k_d  = DATA_SIZE'(k_q);
                if (k_q == C_TWO) begin
                    k_d = '0;
                    if (i_last) begin
                        i_d     = '0;
                        ready_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        i_d = i_q + C_ONE;
                    end
                end else begin
                    k_d = k_q + C_ONE;
                end
            end
            // An empty pass arrives here with READY still low and pulses it one cycle later.
            S_DONE: begin
                if (ready_q) state_d = S_IDLE;
                else         ready_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            r_q        <= '0;
            w_q        <= '0;
            i_q        <= '0;
            k_q        <= '0;
            ready_q    <= 1'b0;
            idx_i_q    <= '0;
            idx_k_q    <= '0;
            k_dat_q    <= '0;
            beta_dat_q <= '0;
            f_dat_q    <= '0;
            pi_dat_q   <= '0;
            k_vld_q    <= 1'b0;
            beta_vld_q <= 1'b0;
            f_vld_q    <= 1'b0;
            pi_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            w_q        <= w_d;
            i_q        <= i_d;
            k_q        <= k_d;
            ready_q    <= ready_d;
            idx_i_q    <= idx_i_d;
            idx_k_q    <= idx_k_d;
            k_dat_q    <= k_dat_d;
            beta_dat_q <= beta_dat_d;
            f_dat_q    <= f_dat_d;
            pi_dat_q   <= pi_dat_d;
            k_vld_q    <= k_vld_d;
            beta_vld_q <= beta_vld_d;
            f_vld_q    <= f_vld_d;
            pi_vld_q   <= pi_vld_d;
        end
    end

    assign READY           = ready_q;
    assign INDEX_I_OUT     = idx_i_q;
    assign INDEX_K_OUT     = idx_k_q;
    assign K_OUT_ENABLE    = k_vld_q;
    assign K_OUT           = k_dat_q;
    assign BETA_OUT_ENABLE = beta_vld_q;
    assign BETA_OUT        = beta_dat_q;
    assign F_OUT_ENABLE    = f_vld_q;
    assign F_OUT           = f_dat_q;
    assign PI_OUT_ENABLE   = pi_vld_q;
    assign PI_OUT          = pi_dat_q;

endmodule

// File: tb/tb_model_read_heads.sv
// Bench for model_read_heads: element-position reference model driven by directed and random passes.
module tb_model_read_heads;

    localparam logic [63:0] ONE = 64'h0000_0001_0000_0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        READY;
    logic [63:0] SIZE_R_IN, SIZE_W_IN;
    logic        XI_IN_ENABLE;
    logic [63:0] XI_IN;
    logic [63:0] INDEX_I_OUT, INDEX_K_OUT;
    logic        K_OUT_ENABLE, BETA_OUT_ENABLE, F_OUT_ENABLE, PI_OUT_ENABLE;
    logic [63:0] K_OUT, BETA_OUT, F_OUT, PI_OUT;

    model_read_heads dut (
        .CLK(CLK), .RST(RST), .START(START), .READY(READY),
        .SIZE_R_IN(SIZE_R_IN), .SIZE_W_IN(SIZE_W_IN),
        .XI_IN_ENABLE(XI_IN_ENABLE), .XI_IN(XI_IN),
        .INDEX_I_OUT(INDEX_I_OUT), .INDEX_K_OUT(INDEX_K_OUT),
        .K_OUT_ENABLE(K_OUT_ENABLE), .K_OUT(K_OUT),
        .BETA_OUT_ENABLE(BETA_OUT_ENABLE), .BETA_OUT(BETA_OUT),
        .F_OUT_ENABLE(F_OUT_ENABLE), .F_OUT(F_OUT),
        .PI_OUT_ENABLE(PI_OUT_ENABLE), .PI_OUT(PI_OUT)
    );

    always #5 CLK = ~CLK;

    int errs   = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pass phase, element position, and the values each output should be holding.
    int          phase;   // 0 idle, 1 consuming, 2 empty-pass wait, 3 ready cycle
    int          m_r, m_w, pos, total;
    logic [63:0] e_k, e_b, e_f, e_p, e_ii, e_kk;

    function automatic logic [63:0] gate(input logic [63:0] x);
`ifdef NTM_READ_HEADS_GATE_CLAMP_EN
        if ($signed(x) < 0) return 64'd0;
        if ($signed(x) > $signed(ONE)) return ONE;
`endif
        return x;
    endfunction

    // Field of element p: 0 key, 1 strength, 2 skipped, 3 free gate, 4 mode.
    task automatic classify(input int p, output int fld, output int ii, output int kk);
        int q = p;
        fld = 2; ii = 0; kk = 0;
        if (q < m_r * m_w) begin fld = 0; ii = q / m_w; kk = q % m_w; return; end
        q -= m_r * m_w;
        if (q < m_r) begin fld = 1; ii = q; return; end
        q -= m_r;
        if (q < 3 * m_w + 1) return;
        q -= 3 * m_w + 1;
        if (q < m_r) begin fld = 3; ii = q; return; end
        q -= m_r;
        if (q < 2) return;
        q -= 2;
        fld = 4; ii = q / 3; kk = q % 3;
    endtask

    task automatic model_clear();
        phase = 0; pos = 0;
        e_k = 0; e_b = 0; e_f = 0; e_p = 0; e_ii = 0; e_kk = 0;
    endtask

    task automatic check_outputs(input logic [3:0] exp_en, input logic exp_rdy);
        check("ready",   {63'd0, READY}, {63'd0, exp_rdy});
        check("k_en",    {63'd0, K_OUT_ENABLE},    {63'd0, exp_en[0]});
        check("beta_en", {63'd0, BETA_OUT_ENABLE}, {63'd0, exp_en[1]});
        check("f_en",    {63'd0, F_OUT_ENABLE},    {63'd0, exp_en[2]});
        check("pi_en",   {63'd0, PI_OUT_ENABLE},   {63'd0, exp_en[3]});
        check("k_out",   K_OUT, e_k);
        check("beta_out", BETA_OUT, e_b);
        check("f_out",   F_OUT, e_f);
        check("pi_out",  PI_OUT, e_p);
        check("index_i", INDEX_I_OUT, e_ii);
        check("index_k", INDEX_K_OUT, e_kk);
    endtask

    task automatic step(input logic st, input logic en, input logic [63:0] xi);
        logic [3:0] exp_en;
        logic       exp_rdy;
        int         fld, ii, kk;
        START = st; XI_IN_ENABLE = en; XI_IN = xi;
        exp_en = '0; exp_rdy = 1'b0;
        case (phase)
            0: if (st) begin
                m_r = int'(SIZE_R_IN); m_w = int'(SIZE_W_IN);
                pos = 0;
                total = m_r * m_w + 5 * m_r + 3 * m_w + 3;
                phase = (m_r == 0 || m_w == 0) ? 2 : 1;
            end
            1: if (en) begin
                classify(pos, fld, ii, kk);
                case (fld)
                    0: begin exp_en[0] = 1'b1; e_k = xi;       e_ii = ii; e_kk = kk; end
                    1: begin exp_en[1] = 1'b1; e_b = xi;       e_ii = ii; e_kk = 0;  end
                    3: begin exp_en[2] = 1'b1; e_f = gate(xi); e_ii = ii; e_kk = 0;  end
                    4: begin exp_en[3] = 1'b1; e_p = gate(xi); e_ii = ii; e_kk = kk; end
                    default: ;
                endcase
                pos++;
                if (pos == total) begin phase = 3; exp_rdy = 1'b1; end
            end
            2: begin phase = 3; exp_rdy = 1'b1; end
            default: phase = 0;
        endcase
        @(posedge CLK);
        #1;
        check_outputs(exp_en, exp_rdy);
    endtask

    task automatic do_reset();
        START = 1'b0; XI_IN_ENABLE = 1'b0;
        RST = 1'b0;
        model_clear();
        #1;
        check_outputs(4'b0, 1'b0);
        #2 RST = 1'b1;
    endtask

    logic [63:0] pool [6];

    // en_mode: 0 always, 1 alternating, 2 random. xi_mode: 0 counting 1.., 1 random, 2 clamp-edge pool.
    task automatic run_pass(input int r, input int w, input int en_mode, input int xi_mode,
                            input bit mid_start, input int rst_after);
        int          n = 0;
        logic [63:0] seq = 64'd1;
        logic        en, st;
        logic [63:0] xi;
        SIZE_R_IN = r; SIZE_W_IN = w;
        step(1'b1, 1'b0, 64'd0);
        while (phase != 0 && n < 3000) begin
            case (en_mode)
                0: en = 1'b1;
                1: en = (n % 2) == 1;
                default: en = $urandom_range(0, 2) != 0;
            endcase
            case (xi_mode)
                0: xi = en ? seq : {$urandom, $urandom};
                1: xi = {$urandom, $urandom};
                default: xi = pool[$urandom_range(0, 5)];
            endcase
            if (en) seq++;
            st = mid_start && ($urandom_range(0, 3) == 0);
            step(st, en, xi);
            n++;
            if (rst_after > 0 && phase == 1 && pos == rst_after) begin
                do_reset();
                return;
            end
        end
        if (n >= 3000) check("pass_timeout", 64'(n), 64'd0);
        for (int j = 0; j < 2; j++) step(1'b0, $urandom_range(0, 1) == 1, {$urandom, $urandom});
    endtask

    initial begin
        pool[0] = 64'h8000_0000_0000_0000;
        pool[1] = 64'h0000_0002_0000_0000;
        pool[2] = ONE;
        pool[3] = ONE + 64'd1;
        pool[4] = 64'h0000_0000_8000_0000;
        pool[5] = 64'hFFFF_FFFF_FFFF_FFFF;
        START = 1'b0; XI_IN_ENABLE = 1'b0; XI_IN = '0;
        SIZE_R_IN = '0; SIZE_W_IN = '0;
        RST = 1'b0;
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        check_outputs(4'b0, 1'b0);
        RST = 1'b1;
        step(1'b0, 1'b1, 64'd99);

        run_pass(2, 3, 0, 0, 1'b0, 0);   // baseline 28-element pass
        run_pass(2, 3, 1, 0, 1'b0, 0);   // alternating stall
        run_pass(0, 5, 0, 0, 1'b0, 0);   // empty pass
        run_pass(3, 0, 2, 1, 1'b0, 0);
        run_pass(2, 3, 0, 0, 1'b0, 10);  // reset after 10th element
        run_pass(2, 3, 0, 0, 1'b0, 0);
        run_pass(2, 3, 0, 0, 1'b1, 0);   // stray START pulses
        run_pass(2, 2, 2, 2, 1'b0, 0);   // clamp edge values
        run_pass(1, 1, 0, 2, 1'b1, 0);

        for (int p = 0; p < 30; p++)
            run_pass($urandom_range(0, 3), $urandom_range(0, 4), 2, $urandom_range(1, 2),
                     $urandom_range(0, 1) == 1,
                     ($urandom_range(0, 5) == 0) ? $urandom_range(1, 12) : 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
